// File: rtl/jpeg_dma_pp_if.sv
// Wishbone master bus of the JPEG ping-pong DMA (read-only, incrementing bursts).
//   adr    : byte address          cyc/stb : cycle / strobe
//   cti    : 010 burst, 111 last   sel/we  : byte lanes / write enable
//   ack    : slave acknowledge     dat_rd  : slave read data
interface jpeg_dma_pp_if;
    logic [31:0] adr;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [3:0]  sel;
    logic        we;
    logic        ack;
    logic [31:0] dat_rd;

    modport master (output adr, cyc, stb, cti, sel, we, input ack, dat_rd);
    modport slave  (input adr, cyc, stb, cti, sel, we, output ack, dat_rd);
endinterface

// File: rtl/jpeg_dma_pp.sv
// Wishbone DMA that fetches BLK_H-line macroblocks into a two-bank input RAM and hands
// each filled bank to the DCT, so the fetch of block n+1 overlaps the DCT of block n.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   dmaen_i, wb_*_i/_o      CPU register slave (word index on wb_adr_i[4:2])
//   wbm                     Wishbone master bus (interface, master modport)
//   bram_addr/data/we_o     input block RAM write port, address {bank, line*WPL+word}
//   start_dct_o, dct_bank_o one-cycle DCT start and the bank it must read
//   dct_busy_i              DCT busy, blocks the handoff
//   irq_o                   frame done and interrupt enabled
module jpeg_dma_pp #(
    parameter int unsigned BLK_H = 8,
    parameter int unsigned WPL   = 2,
    parameter int unsigned BA_W  = 1 + $clog2(BLK_H * WPL)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dmaen_i,
    input  logic [31:0]     wb_adr_i,
    input  logic [31:0]     wb_dat_i,
    input  logic            wb_we_i,
    output logic [31:0]     wb_dat_o,
    jpeg_dma_pp_if.master   wbm,
    output logic [BA_W-1:0] bram_addr_o,
    output logic [31:0]     bram_data_o,
    output logic            bram_we_o,
    output logic            start_dct_o,
    output logic            dct_bank_o,
    input  logic            dct_busy_i,
    output logic            irq_o
);
    localparam int unsigned OW = BA_W - 1;
    localparam int unsigned LW = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int unsigned WW = (WPL > 1) ? $clog2(WPL) : 1;
    localparam logic [LW-1:0] LastLine = LW'(BLK_H - 1);
    localparam logic [WW-1:0] LastWord = WW'(WPL - 1);
    localparam logic [2:0]    CtiInc   = 3'b010;
    localparam logic [2:0]    CtiEnd   = 3'b111;
    localparam logic [2:0]    CtiFirst = (WPL == 1) ? CtiEnd : CtiInc;
    localparam logic [31:0]   BlkBytes = 32'(4 * WPL);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StRelease = 3'd2,
        StHandoff = 3'd3,
        StWaitSw  = 3'd4,
        StDone    = 3'd5
    } state_e;

    state_e        state_q;
    logic [31:0]   src_q;
    logic [11:0]   pitch_q;
    logic [7:0]    endx_q, endy_q, bx_q, by_q;
    logic          auto_q, irq_en_q, done_q, bank_q;
    logic [15:0]   cnt_q;
    logic [LW-1:0] line_q;
    logic [WW-1:0] word_q;
    logic [OW-1:0] off_q;
    // row_base: start of current block row; blk_base: line 0 of current block;
    // line_base: start of current line. Only adders sit in the per-beat path.
    logic [31:0]   row_base_q, blk_base_q, line_base_q, adr_q;
    logic          cyc_q, stb_q;
    logic [2:0]    cti_q;

    logic [2:0]  reg_idx;
    logic        reg_wr, wr_ctrl, busy, wait_sw;
    logic        ctl_start, ctl_next, ctl_abort, ctl_clr, last_blk, row_wrap;
    logic [31:0] pitch_w, pitch_blk, next_blk_base;
    logic        unused_adr;

    assign reg_idx   = wb_adr_i[4:2];
    assign reg_wr    = dmaen_i & wb_we_i;
    assign wr_ctrl   = reg_wr && (reg_idx == 3'd4);
    assign ctl_start = wr_ctrl & wb_dat_i[0];
    assign ctl_next  = wr_ctrl & wb_dat_i[1];
    assign ctl_abort = wr_ctrl & wb_dat_i[4];
    assign ctl_clr   = wr_ctrl & wb_dat_i[5];
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign wait_sw   = (state_q == StWaitSw);
    assign last_blk  = (bx_q == endx_q) && (by_q == endy_q);
    assign row_wrap  = (bx_q == endx_q);
    assign pitch_w   = {20'd0, pitch_q};
    assign pitch_blk = pitch_w * 32'(BLK_H);
    assign next_blk_base = row_wrap ? (row_base_q + pitch_blk) : (blk_base_q + BlkBytes);
    assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

    assign wbm.adr = adr_q;
    assign wbm.cyc = cyc_q;
    assign wbm.stb = stb_q;
    assign wbm.cti = cti_q;
    assign wbm.sel = 4'b1111;
    assign wbm.we  = 1'b0;
    assign irq_o   = done_q & irq_en_q;

    always_comb begin
        wb_dat_o = '0;
        case (reg_idx)
            3'd0: wb_dat_o = src_q;
            3'd1: wb_dat_o = pitch_w;
            3'd2: wb_dat_o = {24'd0, endx_q};
            3'd3: wb_dat_o = {24'd0, endy_q};
            3'd4: wb_dat_o = {21'd0, state_q, 2'b00, bank_q, irq_en_q, auto_q, done_q,
                              wait_sw, busy};
            3'd5: wb_dat_o = {16'd0, cnt_q};
            default: wb_dat_o = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            src_q       <= '0;
            pitch_q     <= '0;
            endx_q      <= '0;
            endy_q      <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            auto_q      <= 1'b0;
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            bank_q      <= 1'b0;
            cnt_q       <= '0;
            line_q      <= '0;
            word_q      <= '0;
            off_q       <= '0;
            row_base_q  <= '0;
            blk_base_q  <= '0;
            line_base_q <= '0;
            adr_q       <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            cti_q       <= '0;
            bram_addr_o <= '0;
            bram_data_o <= '0;
            bram_we_o   <= 1'b0;
            start_dct_o <= 1'b0;
            dct_bank_o  <= 1'b0;
        end else begin
            start_dct_o <= 1'b0;
            bram_we_o   <= 1'b0;

            if (reg_wr && !busy) begin
                case (reg_idx)
                    3'd0: src_q   <= wb_dat_i;
                    3'd1: pitch_q <= wb_dat_i[11:0];
                    3'd2: endx_q  <= wb_dat_i[7:0];
                    3'd3: endy_q  <= wb_dat_i[7:0];
                    default: ;
                endcase
            end
            if (wr_ctrl) begin
                auto_q   <= wb_dat_i[2];
                irq_en_q <= wb_dat_i[3];
            end
            if (ctl_clr) begin
                done_q <= 1'b0;
            end

            if (ctl_abort) begin
                // Abort beats start: an ack seen this cycle is dropped, not written.
                state_q <= StIdle;
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (ctl_start) begin
                            bx_q        <= '0;
                            by_q        <= '0;
                            line_q      <= '0;
                            word_q      <= '0;
                            off_q       <= '0;
                            bank_q      <= 1'b0;
                            done_q      <= 1'b0;
                            cnt_q       <= '0;
                            row_base_q  <= src_q;
                            blk_base_q  <= src_q;
                            line_base_q <= src_q;
                            adr_q       <= src_q;
                            cti_q       <= CtiFirst;
                            cyc_q       <= 1'b1;
                            stb_q       <= 1'b1;
                            state_q     <= StFetch;
                        end
                    end
                    StFetch: begin
                        if (wbm.ack) begin
                            bram_we_o   <= 1'b1;
                            bram_data_o <= wbm.dat_rd;
                            bram_addr_o <= {bank_q, off_q};
                            off_q       <= off_q + OW'(1);
                            if (word_q == LastWord) begin
                                word_q <= '0;
                                cyc_q  <= 1'b0;
                                stb_q  <= 1'b0;
                                cti_q  <= CtiFirst;
                                if (line_q == LastLine) begin
                                    line_q  <= '0;
                                    state_q <= StHandoff;
                                end else begin
                                    line_q      <= line_q + LW'(1);
                                    line_base_q <= line_base_q + pitch_w;
                                    adr_q       <= line_base_q + pitch_w;
                                    state_q     <= StRelease;
                                end
                            end else begin
                                word_q <= word_q + WW'(1);
                                adr_q  <= adr_q + 32'd4;
                                cti_q  <= (word_q + WW'(1) == LastWord) ? CtiEnd : CtiInc;
                            end
                        end
                    end
                    StRelease: begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        state_q <= StFetch;
                    end
                    StHandoff: begin
                        if (!dct_busy_i) begin
                            start_dct_o <= 1'b1;
                            dct_bank_o  <= bank_q;
                            bank_q      <= ~bank_q;
                            cnt_q       <= cnt_q + 16'd1;
                            off_q       <= '0;
                            if (last_blk) begin
                                state_q <= StDone;
                            end else begin
                                if (row_wrap) begin
                                    bx_q       <= '0;
                                    by_q       <= by_q + 8'd1;
                                    row_base_q <= next_blk_base;
                                end else begin
                                    bx_q <= bx_q + 8'd1;
                                end
                                blk_base_q  <= next_blk_base;
                                line_base_q <= next_blk_base;
                                adr_q       <= next_blk_base;
                                if (auto_q) begin
                                    cyc_q   <= 1'b1;
                                    stb_q   <= 1'b1;
                                    state_q <= StFetch;
                                end else begin
                                    state_q <= StWaitSw;
                                end
                            end
                        end
                    end
                    StWaitSw: begin
                        if (ctl_next) begin
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            state_q <= StFetch;
                        end
                    end
                    StDone: begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end
endmodule

// File: doc/jpeg_dma_pp.md
Name: jpeg_dma_pp

Overview:
Parametrised Wishbone DMA that fetches BLK_H-line image macroblocks from memory into a ping-pong (two-bank) input block RAM and hands each filled bank to the DCT. Line fetches use Wishbone incrementing bursts, so fetching block n+1 overlaps the DCT on block n. It supports a manual mode, where software acknowledges each block, and an auto mode, where the whole frame runs without CPU help. It sits between the CPU register bus, the Wishbone master port and the DCT front end.

Parameters:
BLK_H, 8, lines per block.
WPL, 2, 32-bit words per block line (block width = 4*WPL bytes).
BA_W, 1+$clog2(BLK_H*WPL), bram word-address width; MSB = bank.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
dmaen_i  in  1  register-slave select
wb_adr_i  in  32  register address, [4:2] used
wb_dat_i  in  32  register write data
wb_we_i  in  1  register write strobe (qualified by dmaen_i)
wb_dat_o  out  32  register read data (combinational on wb_adr_i)
wbm_adr_o  out  32  master byte address
wbm_cyc_o  out  1  master cycle
wbm_stb_o  out  1  master strobe
wbm_cti_o  out  3  cycle type: 010 incrementing, 111 end of burst
wbm_sel_o  out  4  constant 4'b1111
wbm_we_o  out  1  constant 0
wbm_ack_i  in  1  master acknowledge
wbm_dat_i  in  32  master read data
bram_addr_o  out  BA_W  bram word address {bank, line*WPL+word}
bram_data_o  out  32  bram write data
bram_we_o  out  1  bram write enable
start_dct_o  out  1  one-cycle DCT start pulse
dct_bank_o  out  1  bank the DCT must read; valid with start_dct_o, held until the next start
dct_busy_i  in  1  DCT busy
irq_o  out  1  level interrupt: frame done and IRQ enabled

Behaviour:
- Registers ([4:2]): 0 srcaddr; 1 pitch[11:0]; 2 endblock_x[7:0]; 3 endblock_y[7:0]; 4 control (write) / status (read); 5 blocks-done counter[15:0] (read-only).
- Control write bits: 0 start, 1 nextblock, 2 auto, 3 irq_en, 4 abort, 5 clear done. Status read bits: 0 busy, 1 wait_sw, 2 done, 3 auto, 4 irq_en, 5 current fill bank, [10:8] state.
- Writes to registers 0-3, and start, are ignored while busy=1. Bits 2/3 are always writable.
- Reset (async): state IDLE; all outputs and registers 0; fill bank 0.
- States: IDLE, FETCH, RELEASE, HANDOFF, WAIT_SW, DONE.
- IDLE: on start, latch position (bx=by=line=word=0, bank 0), clear done and the counter, go to FETCH.
- FETCH: cyc=stb=1. Address = srcaddr + (by*BLK_H+line)*pitch + bx*4*WPL + word*4, computed incrementally (no multiplier in the per-beat path). cti=010, except 111 on word WPL-1.
- Each ack advances word. At line end, drop cyc/stb the same cycle and go to RELEASE (exactly one cycle with cyc=0), except after the last line of the block, which goes to HANDOFF. Wait states (ack low) hold address and strobe.
- Bram write: registered, one cycle after ack. bram_we_o=1 with data=wbm_dat_i of that ack and addr={bank, line*WPL+word}.
- HANDOFF: wait until dct_busy_i=0, then pulse start_dct_o for one cycle with dct_bank_o=bank, flip the fill bank, and increment the counter.
- After the handoff pulse:
  - last block (bx==endblock_x && by==endblock_y): go to DONE.
  - otherwise advance bx, wrapping to 0 and incrementing by at endblock_x. Auto mode goes to FETCH; manual mode goes to WAIT_SW.
- WAIT_SW: stays until a nextblock write, then FETCH. A nextblock write outside WAIT_SW is ignored.
- DONE: set done, busy=0, return to IDLE the next cycle. irq_o = done & irq_en, cleared by the clear-done write or by start.
- Abort (any state): next cycle cyc/stb=0, no further bram writes, no start_dct, state IDLE, done stays 0. A pending registered bram write from an ack already taken still completes.
- Simultaneous start and abort: abort wins.
- pitch and addresses wrap modulo 2^32; no alignment check (srcaddr and pitch are word aligned by contract).

Test Plan:
1. Manual single block: srcaddr=0x1000, pitch=64, endx=endy=0, zero-wait ack. Expect 8 two-beat bursts at 0x1000/0x1004, 0x1040/0x1044 … 0x11C0/0x11C4, one idle cycle between bursts, 16 bram writes at addr 0-15, one start_dct with bank 0, then done=1 and irq_o=1 (irq_en=1).
2. Auto 2x2 frame, pitch=16, dct_busy pulsed 40 cycles after each start. Expect 4 start_dct pulses with banks 0,1,0,1. Block (1,0) first address srcaddr+8; block (0,1) first address srcaddr+128. Counter=4.
3. Overlap/backpressure: hold dct_busy=1 after the first start. Block 2 fills bank 1 fully, then the FSM holds in HANDOFF with no bank-0 writes until busy drops; start follows one cycle later.
4. Random 0-3 wait states on ack. Bram contents equal the memory model, and cti=111 only on second beats.
5. Abort written mid-burst (after 5 acks). Expect cyc low the next cycle, at most one more bram write, IDLE, busy=0, done=0. A new start then runs cleanly from srcaddr.
6. Async rst_i asserted mid-line between clock edges. Expect all outputs 0 immediately. Writes to srcaddr while busy leave it unchanged.
